// File: rtl/rtc_pkg.sv
// Shared types and constants for the time-of-day core.
package rtc_pkg;

  typedef enum logic [1:0] {StRun, StSetH, StSetM, StSetS} rtc_state_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  localparam int unsigned BLANK_HOUR = 2;
  localparam int unsigned BLANK_MIN  = 1;
  localparam int unsigned BLANK_SEC  = 0;

  // One step up or down with wrap-around at 0 and max_val.
  function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max_val,
                                           input logic dec);
    logic [5:0] res;
    if (dec) res = (val == 6'd0) ? max_val : val - 6'd1;
    else     res = (val == max_val) ? 6'd0 : val + 6'd1;
    return res;
  endfunction

endpackage

// File: rtl/rtc_if.sv
// Button, configuration and time/display signals of the front-panel clock core.
interface rtc_if;
  logic       mode;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       enter;
  logic       esc;
  logic       h12;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] disp_hour;
  logic       pm;
  logic       norm;
  logic [2:0] blank;
  logic       day_pulse;
  logic       alarm;

  modport master (
    output mode, up, down, left, right, enter, esc, h12, alarm_en, alarm_hour, alarm_min,
    input  hour, min, sec, disp_hour, pm, norm, blank, day_pulse, alarm
  );

  modport slave (
    input  mode, up, down, left, right, enter, esc, h12, alarm_en, alarm_hour, alarm_min,
    output hour, min, sec, disp_hour, pm, norm, blank, day_pulse, alarm
  );
endinterface

// File: rtl/rtc_core_btn_repeat.sv
// Rising-edge detector with auto-repeat: first repeat DELAY cycles after the press,
// then every PERIOD cycles while the button stays held.
module btn_repeat #(
  parameter int unsigned DELAY  = 500,
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam int unsigned CntMax = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DelayCnt  = CntW'(DELAY);
  localparam logic [CntW-1:0] PeriodCnt = CntW'(PERIOD);

  logic            btn_q;
  logic            rpt_q, rpt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press, held, rpt_evt;

  // cnt_q holds the number of cycles since the last press or repeat event.
  always_comb begin
    press   = btn & ~btn_q;
    held    = btn & btn_q;
    rpt_evt = held & (cnt_q == (rpt_q ? PeriodCnt : DelayCnt));
    cnt_d   = '0;
    rpt_d   = 1'b0;
    if (press) begin
      cnt_d = CntW'(1);
    end else if (rpt_evt) begin
      cnt_d = CntW'(1);
      rpt_d = 1'b1;
    end else if (held) begin
      cnt_d = cnt_q + 1'b1;
      rpt_d = rpt_q;
    end
    evt = press | rpt_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      rpt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn;
      rpt_q <= rpt_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_core.sv
// Time-of-day core: seconds timekeeping, RUN/SET field editor, 12/24h display,
// day-rollover strobe, acknowledgeable alarm and per-field blink mask.
module rtc_core
  import rtc_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter int unsigned BLINK_HALF    = 250
) (
  input logic  clk,
  input logic  rst,
  rtc_if.slave rtc_io
);

  localparam int unsigned TickW  = $clog2(TICKS_PER_SEC);
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TickW-1:0]  TickLast  = TickW'(TICKS_PER_SEC - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

  rtc_state_e      state_q, state_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            norm_q, norm_d;
  logic [2:0]      blank_q, blank_d;
  logic            day_q, day_d;
  logic            alarm_q, alarm_d;
  logic            ack_q, ack_d;
  logic [3:0]      btn_q;

  logic up_evt, dn_evt, left_evt, right_evt, enter_evt, esc_evt;
  logic any_evt, match, fld_change;
  logic [5:0] hour_step;

  btn_repeat #(
    .DELAY (REPEAT_DELAY),
    .PERIOD(REPEAT_PERIOD)
  ) u_up_rpt (
    .clk(clk),
    .rst(rst),
    .btn(rtc_io.up),
    .evt(up_evt)
  );

  btn_repeat #(
    .DELAY (REPEAT_DELAY),
    .PERIOD(REPEAT_PERIOD)
  ) u_dn_rpt (
    .clk(clk),
    .rst(rst),
    .btn(rtc_io.down),
    .evt(dn_evt)
  );

  assign left_evt  = rtc_io.left  & ~btn_q[0];
  assign right_evt = rtc_io.right & ~btn_q[1];
  assign enter_evt = rtc_io.enter & ~btn_q[2];
  assign esc_evt   = rtc_io.esc   & ~btn_q[3];
  assign any_evt   = up_evt | dn_evt | left_evt | right_evt | enter_evt | esc_evt;

  assign match = rtc_io.alarm_en & norm_q & (hour_q == rtc_io.alarm_hour) &
                 (min_q == rtc_io.alarm_min);

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    tick_d     = '0;
    day_d      = 1'b0;
    fld_change = 1'b0;
    hour_step  = '0;

    if (state_q == StRun) begin
      if (tick_q == TickLast) begin
        sec_d = wrap_step(sec_q, SEC_MAX, 1'b0);
        if (sec_q == SEC_MAX) begin
          min_d = wrap_step(min_q, MIN_MAX, 1'b0);
          if (min_q == MIN_MAX) begin
            hour_step = wrap_step({1'b0, hour_q}, HOUR_MAX, 1'b0);
            hour_d    = hour_step[4:0];
            day_d     = ({1'b0, hour_q} == HOUR_MAX);
          end
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    // Exit beats field move beats value step; simultaneous opposites cancel.
    if (!rtc_io.mode) begin
      state_d = StRun;
    end else if (state_q == StRun) begin
      if (enter_evt) begin
        state_d    = StSetH;
        fld_change = 1'b1;
      end
    end else if (esc_evt | enter_evt) begin
      state_d = StRun;
    end else if (left_evt ^ right_evt) begin
      fld_change = 1'b1;
      case (state_q)
        StSetH:  state_d = right_evt ? StSetM : StSetS;
        StSetM:  state_d = right_evt ? StSetS : StSetH;
        default: state_d = right_evt ? StSetH : StSetM;
      endcase
    end else if (up_evt ^ dn_evt) begin
      case (state_q)
        StSetH: begin
          hour_step = wrap_step({1'b0, hour_q}, HOUR_MAX, dn_evt);
          hour_d    = hour_step[4:0];
        end
        StSetM:  min_d = wrap_step(min_q, MIN_MAX, dn_evt);
        default: sec_d = wrap_step(sec_q, SEC_MAX, dn_evt);
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if ((state_d != StRun) && !fld_change) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
    blank_d = '0;
    case (state_d)
      StSetH:  blank_d[BLANK_HOUR] = blink_d;
      StSetM:  blank_d[BLANK_MIN]  = blink_d;
      StSetS:  blank_d[BLANK_SEC]  = blink_d;
      default: blank_d = '0;
    endcase
    norm_d  = (state_d == StRun);
    ack_d   = match & (ack_q | (rtc_io.mode & (state_q == StRun) & any_evt));
    alarm_d = match & ~ack_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tick_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      norm_q      <= 1'b1;
      blank_q     <= '0;
      day_q       <= 1'b0;
      alarm_q     <= 1'b0;
      ack_q       <= 1'b0;
      btn_q       <= '0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      norm_q      <= norm_d;
      blank_q     <= blank_d;
      day_q       <= day_d;
      alarm_q     <= alarm_d;
      ack_q       <= ack_d;
      btn_q       <= {rtc_io.esc, rtc_io.enter, rtc_io.right, rtc_io.left};
    end
  end

  always_comb begin
    if (rtc_io.h12) begin
      if (hour_q == 5'd0)       rtc_io.disp_hour = 5'd12;
      else if (hour_q > 5'd12)  rtc_io.disp_hour = hour_q - 5'd12;
      else                      rtc_io.disp_hour = hour_q;
      rtc_io.pm = (hour_q >= 5'd12);
    end else begin
      rtc_io.disp_hour = hour_q;
      rtc_io.pm        = 1'b0;
    end
  end

  assign rtc_io.hour      = hour_q;
  assign rtc_io.min       = min_q;
  assign rtc_io.sec       = sec_q;
  assign rtc_io.norm      = norm_q;
  assign rtc_io.blank     = blank_q;
  assign rtc_io.day_pulse = day_q;
  assign rtc_io.alarm     = alarm_q;

endmodule

// File: doc/rtc_core.md
# rtc_core

Parametrised time-of-day core for the front-panel clock: keeps hours/minutes/seconds from a divided system clock and lets the user edit them through a RUN/SET field FSM with auto-repeating up/down. It adds 12/24-hour display, a single-cycle day-rollover pulse, an acknowledgeable alarm and a per-field blank mask. The blank mask drives the existing digit-split / seven-segment / blink path, which stays outside this block.

## Interface
- `TICKS_PER_SEC`, 1000: `clk` cycles per second (≥2).
- `REPEAT_DELAY`, 500: cycles an up/down button is held before auto-repeat starts.
- `REPEAT_PERIOD`, 100: cycles between auto-repeat steps.
- `BLINK_HALF`, 250: cycles per blink half-period.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: reset is synchronous and active-high.
- `mode` in 1: 1 = editing allowed; 0 = forced RUN, buttons ignored.
- `up`, `down`, `left`, `right`, `enter`, `esc` in 1 each: raw, already-debounced buttons.
- `h12` in 1: 1 = 12-hour display, 0 = 24-hour display.
- `alarm_en` in 1: alarm enable.
- `alarm_hour` in 5: alarm hour, 0–23.
- `alarm_min` in 6: alarm minute, 0–59.
- `hour` out 5: internal hour, 0–23.
- `min` out 6: minutes, 0–59.
- `sec` out 6: seconds, 0–59.
- `disp_hour` out 5: displayed hour (1–12 or 0–23).
- `pm` out 1: PM flag; always 0 when `h12`=0.
- `norm` out 1: 1 in RUN.
- `blank` out 3: {hour, min, sec} blank mask.
- `day_pulse` out 1: one-cycle rollover strobe.
- `alarm` out 1: alarm level.

## Operation
- States: RUN, SET_H, SET_M, SET_S.
- Reset: RUN; time 00:00:00; tick counter 0; `norm`=1; `blank`=0; `day_pulse`=0; `alarm`=0; alarm-ack=0; all button history=0.
- Button event: input high this cycle and low last cycle. Up/down also fire auto-repeat events: first at REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles while held. Left/right/enter/esc never repeat.
- RUN:
  - `enter` event with `mode`=1 → SET_H.
  - Any button event acknowledges a sounding alarm.
- SET states:
  - Event priority: `esc` / `enter` > left/right > up/down.
  - `esc` or `enter` → RUN.
  - `left` moves H←M←S←H (from H, wraps to S); `right` moves H→M→S→H.
  - `left` and `right` in the same cycle: no move.
  - `up` increments the selected field, wrapping 23→0 or 59→0. `down` decrements, wrapping 0→23 or 0→59.
  - `up` and `down` in the same cycle: no change.
- `mode`=0 in any state → RUN next cycle. No button acts in that cycle.
- Timekeeping (RUN only):
  - Tick counter counts 0..TICKS_PER_SEC-1. At the terminal count, `sec` advances with cascaded carries.
  - On 23:59:59→00:00:00, `day_pulse`=1 for exactly that one cycle.
  - In SET states the tick counter is held at 0. Time does not advance; no backlog is kept.
- Alarm:
  - Match = `alarm_en` & `norm` & `hour`==`alarm_hour` & `min`==`alarm_min`.
  - `alarm` = match & !ack.
  - The ack bit clears whenever match is 0.
- 12-hour display (`h12`=1):
  - `disp_hour` = 12 when `hour`=0; `hour`−12 when `hour`>12; otherwise `hour`.
  - `pm` = (`hour`≥12).
- Blink: in SET, only the selected field's `blank` bit toggles every BLINK_HALF cycles. It starts at 0 (visible) on SET entry and on every field change. In RUN, `blank`=0.

## Timing
- Registered outputs (`hour`, `min`, `sec`, `norm`, `blank`, `day_pulse`, `alarm`) update on the posedge after the causing event: 1-cycle latency.
- `disp_hour` and `pm` are combinational from `hour` and `h12`: 0 latency.
- Second boundary: `sec` changes on the edge where the counter wraps, i.e. TICKS_PER_SEC cycles after RUN entry or reset.
- Leaving SET: the counter restarts at 0, so the first second is a full TICKS_PER_SEC cycles.
- `rst` mid-edit: returns to RUN 00:00:00 next edge. Repeat timers and the blink counter clear.
- An auto-repeat event coinciding with a left/right event in the same cycle: the field move wins and the step is dropped.
- The repeat timer restarts on every press event.

## Structure
- Shared package `rtc_pkg`:
  - state enum {RUN, SET_H, SET_M, SET_S};
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59;
  - field-index constants for `blank` bits.
- Sub-module `btn_repeat` (param DELAY, PERIOD; ports `clk`, `rst`, `btn`, `evt`), instantiated for up and down.
- Plain edge detect (no repeat) is done inline for the other four buttons.

## Test plan
- Reset, run 3·TICKS_PER_SEC cycles → `sec`=3, `min`=0, `hour`=0, `norm`=1, `blank`=000.
- Preset 23:59:59 via SET then `esc`; after TICKS_PER_SEC cycles → 00:00:00 with `day_pulse` high for exactly 1 cycle.
- `enter`, `left` ×1, `down` ×1 from 00:00:00 → SET_S, `sec`=59. Then `right` → SET_H; `up` → `hour`=1; blank bit 2 toggles every BLINK_HALF cycles.
- Hold `up` in SET_M for REPEAT_DELAY + 3·REPEAT_PERIOD cycles → `min` advanced by exactly 5 (press + 4 repeats).
- `h12`=1 at hours 0, 12, 13 → `disp_hour`/`pm` = 12/0, 12/1, 1/1. `h12`=0 at hour 13 → `disp_hour`=13, `pm`=0.
- Alarm 00:01 with `alarm_en`=1: run to 00:01:00 → `alarm`=1. Press `left` → `alarm`=0 next cycle and stays 0 through 00:01:59. Mid-SET `rst` → 00:00:00 RUN.
